// File: rtl/stereo_input_sync_pkg.sv
// Shared definitions for the stereo input synchroniser.
// Holds the FSM state encoding, coordinate/pixel/entry/counter widths,
// the packed FIFO entry layout and a raster-order helper.
package stereo_sync_pkg;

    localparam int COORD_W = 10;
    localparam int PIX_W   = 8;
    localparam int ENTRY_W = 2 * COORD_W + PIX_W;
    localparam int CNT_W   = 16;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // One buffered pixel: {y, x, pix}, 28 bits.
    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
        logic [PIX_W-1:0]   pix;
    } entry_t;

    // True when a comes before b in raster order (row first, then column).
    function automatic logic rasterBefore(entry_t a, entry_t b);
        return (a.y < b.y) || ((a.y == b.y) && (a.x < b.x));
    endfunction

endpackage

// File: rtl/stereo_input_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO used once per camera eye.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   flush_i          - synchronous flush; empties the FIFO and clears ovf_o
//   push_i, data_i   - write request and data
//   pop_i            - read request; head_o advances on this edge
//   head_o           - current head entry (valid while empty_o is 0)
//   empty_o, full_o  - occupancy flags
//   ovf_o            - set by a push into a full FIFO with no pop, held until flush
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             ovf_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rdPtr_q];
    assign ovf_o   = ovf_q;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Storage array carries no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (doPush && !reset && !flush_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointer, occupancy and overflow bookkeeping; DEPTH is a power of two,
    // so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
            if (push_i && full_o && !doPop) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stereo_input_sync.sv
// stereo_input_sync: aligns two independently timed camera streams into
// raster-ordered left/right pixel pairs for the stereo pipeline.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   left_x/y/pix/val            - left camera pixel stream
//   right_x/y/pix/val           - right camera pixel stream
//   out_x/y/left/right/is_val   - registered aligned pair, one-cycle qualifier
//   locked                      - high while the aligner is in ST_RUN
//   overflow                    - sticky FIFO overflow flag
//   drop_cnt, resync_cnt        - saturating statistics counters
// Build option: define SYNC_STATS_EN to implement drop_cnt/resync_cnt;
// otherwise both are tied to zero.
module stereo_input_sync
    import stereo_sync_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ROW_SZ     = 320,
    parameter int COL_SZ     = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] left_x,
    input  logic [COORD_W-1:0] left_y,
    input  logic [PIX_W-1:0]   left_pix,
    input  logic               left_val,
    input  logic [COORD_W-1:0] right_x,
    input  logic [COORD_W-1:0] right_y,
    input  logic [PIX_W-1:0]   right_pix,
    input  logic               right_val,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [PIX_W-1:0]   out_left,
    output logic [PIX_W-1:0]   out_right,
    output logic               out_is_val,
    output logic               locked,
    output logic               overflow,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   resync_cnt
);

    entry_t             lIn, rIn, lHead, rHead;
    logic               lPush, rPush;
    logic               lEmpty, rEmpty, lFull, rFull, lOvf, rOvf;
    logic               lOrigin, rOrigin, sameCoord;
    logic               popL, popR, emit, flush;
    state_e             state_q, state_d;
    logic               outVal_q;
    logic [COORD_W-1:0] outX_q, outY_q;
    logic [PIX_W-1:0]   outL_q, outR_q;
    logic               overflow_q;

    assign lIn = {left_y, left_x, left_pix};
    assign rIn = {right_y, right_x, right_pix};

    // Out-of-frame coordinates never enter the FIFOs.
    assign lPush = left_val  && (left_x  < COORD_W'(ROW_SZ)) && (left_y  < COORD_W'(COL_SZ));
    assign rPush = right_val && (right_x < COORD_W'(ROW_SZ)) && (right_y < COORD_W'(COL_SZ));

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_leftFifo (
        .clk(clk), .reset(reset), .flush_i(flush),
        .push_i(lPush), .data_i(lIn), .pop_i(popL),
        .head_o(lHead), .empty_o(lEmpty), .full_o(lFull), .ovf_o(lOvf)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_rightFifo (
        .clk(clk), .reset(reset), .flush_i(flush),
        .push_i(rPush), .data_i(rIn), .pop_i(popR),
        .head_o(rHead), .empty_o(rEmpty), .full_o(rFull), .ovf_o(rOvf)
    );

    assign lOrigin   = !lEmpty && (lHead.x == '0) && (lHead.y == '0);
    assign rOrigin   = !rEmpty && (rHead.x == '0) && (rHead.y == '0);
    assign sameCoord = (lHead.x == rHead.x) && (lHead.y == rHead.y);

    // Alignment FSM. A pending FIFO overflow outranks everything: both FIFOs
    // are flushed and the aligner hunts for the next frame start. In HUNT,
    // non-origin heads are discarded while an origin head waits for its
    // partner. In RUN, the raster-earlier head of a mismatched pair is
    // discarded so the streams converge on a common coordinate.
    always_comb begin
        popL    = 1'b0;
        popR    = 1'b0;
        emit    = 1'b0;
        flush   = 1'b0;
        state_d = state_q;
        if (lOvf || rOvf) begin
            flush   = 1'b1;
            state_d = ST_HUNT;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (lOrigin && rOrigin) begin
                        popL    = 1'b1;
                        popR    = 1'b1;
                        emit    = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        popL = !lEmpty && !lOrigin;
                        popR = !rEmpty && !rOrigin;
                    end
                end
                ST_RUN: begin
                    if (!lEmpty && !rEmpty) begin
                        if (sameCoord) begin
                            popL = 1'b1;
                            popR = 1'b1;
                            emit = 1'b1;
                        end else if (rasterBefore(lHead, rHead)) begin
                            popL = 1'b1;
                        end else begin
                            popR = 1'b1;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // State, registered output pair and sticky overflow. The pair fields
    // hold their last value whenever nothing is emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            outVal_q   <= 1'b0;
            outX_q     <= '0;
            outY_q     <= '0;
            outL_q     <= '0;
            outR_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            outVal_q <= emit;
            if (emit) begin
                outX_q <= lHead.x;
                outY_q <= lHead.y;
                outL_q <= lHead.pix;
                outR_q <= rHead.pix;
            end
            if (!flush && ((lPush && lFull && !popL) || (rPush && rFull && !popR))) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_x      = outX_q;
    assign out_y      = outY_q;
    assign out_left   = outL_q;
    assign out_right  = outR_q;
    assign out_is_val = outVal_q;
    assign locked     = (state_q == ST_RUN);
    assign overflow   = overflow_q;

`ifdef SYNC_STATS_EN
    logic [CNT_W-1:0] dropCnt_q, resyncCnt_q;
    logic [1:0]       dropInc;
    logic [CNT_W:0]   dropSum;

    // Every pop that is not part of an emitted pair is a discarded head;
    // in HUNT both eyes can discard on the same edge.
    always_comb begin
        dropInc = emit ? 2'd0 : (2'(popL) + 2'(popR));
        dropSum = {1'b0, dropCnt_q} + (CNT_W+1)'(dropInc);
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropCnt_q   <= '0;
            resyncCnt_q <= '0;
        end else begin
            dropCnt_q <= dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
            if (flush && (state_q == ST_RUN) && (resyncCnt_q != '1)) begin
                resyncCnt_q <= resyncCnt_q + 1'b1;
            end
        end
    end

    assign drop_cnt   = dropCnt_q;
    assign resync_cnt = resyncCnt_q;
`else
    assign drop_cnt   = '0;
    assign resync_cnt = '0;
`endif

endmodule
